// File: rtl/md5_pkg.sv
// Shared MD5 constants, types and index helpers for the md5_update engine.
package md5_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } md5_words_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam md5_words_t  IV   = '{a: IV_A, b: IV_B, c: IV_C, d: IV_D};

    // K[i] = floor(|sin(i+1)| * 2^32)
    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TAB [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // Message word index; every multiplier result is taken mod 16, so only i[3:0] matters.
    function automatic logic [3:0] g_index(input logic [5:0] i);
        logic [3:0] lo;
        lo = i[3:0];
        case (i[5:4])
            2'd0:    g_index = lo;
            2'd1:    g_index = lo * 4'd5 + 4'd1;
            2'd2:    g_index = lo * 4'd3 + 4'd5;
            default: g_index = lo * 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, constant add, rotate, register shuffle.
module md5_step
    import md5_pkg::*;
(
    input  md5_words_t  cur,
    input  logic [31:0] m_g,
    input  logic [5:0]  i,
    output md5_words_t  nxt
);

    logic [31:0] f;
    logic [31:0] tmp;
    logic [63:0] dbl;

    always_comb begin
        case (i[5:4])
            2'd0:    f = (cur.b & cur.c) | (~cur.b & cur.d);
            2'd1:    f = (cur.d & cur.b) | (~cur.d & cur.c);
            2'd2:    f = cur.b ^ cur.c ^ cur.d;
            default: f = cur.c ^ (cur.b | ~cur.d);
        endcase
        tmp = cur.a + f + K_TAB[i] + m_g;
        // upper half of the doubled word shifted left is the left rotate
        dbl = {tmp, tmp} << S_TAB[i];
        nxt.a = cur.d;
        nxt.d = cur.c;
        nxt.c = cur.b;
        nxt.b = cur.b + dbl[63:32];
    end

endmodule

// File: rtl/md5_update.sv
// Single-block MD5 compression with chaining digest A..D.
// MD5_UNROLL2_EN: evaluate two chained steps per clock (32-cycle ROUND phase).
module md5_update
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         en,
    input  logic [511:0] string_data,
    input  logic [8:0]   input_len,
    output logic         complete,
    output logic [31:0]  A,
    output logic [31:0]  B,
    output logic [31:0]  C,
    output logic [31:0]  D
);

`ifdef MD5_UNROLL2_EN
    localparam int ROUNDS_PER_CYCLE = 2;
`else
    localparam int ROUNDS_PER_CYCLE = 1;
`endif
    localparam logic [5:0] I_INC  = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_I = 6'(64 - ROUNDS_PER_CYCLE);

    state_t            state, state_nxt;
    md5_words_t        digest, work, step_out;
    logic [15:0][31:0] blk;
    logic [8:0]        len_q;
    logic [5:0]        i;

    // Byte count travels with the block for downstream visibility only.
    logic unused_len;
    assign unused_len = ^len_q;

    assign A = digest.a;
    assign B = digest.b;
    assign C = digest.c;
    assign D = digest.d;

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_step
        md5_words_t cur, nxt;
        logic [5:0] idx;
        if (r == 0) begin : g_head
            assign cur = work;
        end else begin : g_link
            assign cur = g_step[r-1].nxt;
        end
        assign idx = i + 6'(r);
        md5_step u_step (
            .cur (cur),
            .m_g (blk[g_index(idx)]),
            .i   (idx),
            .nxt (nxt)
        );
    end
    assign step_out = g_step[ROUNDS_PER_CYCLE-1].nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ROUND;
            ROUND:   if (i == LAST_I) state_nxt = ADD;
            ADD:     state_nxt = DONE;
            DONE:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digest   <= IV;
            work     <= '0;
            blk      <= '0;
            len_q    <= '0;
            i        <= '0;
            complete <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) digest <= IV;
                    if (en) begin
                        blk   <= string_data;
                        len_q <= input_len;
                        i     <= '0;
                        // init in the same cycle must seed this block with the IV
                        work  <= init ? IV : digest;
                    end
                end
                ROUND: begin
                    work <= step_out;
                    i    <= i + I_INC;
                end
                ADD: begin
                    digest.a <= digest.a + work.a;
                    digest.b <= digest.b + work.b;
                    digest.c <= digest.c + work.c;
                    digest.d <= digest.d + work.d;
                    complete <= 1'b1;
                end
                DONE: begin
                    if (init) digest <= IV;
                    if (!en) complete <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_update.sv
// Scoreboarded bench for md5_update: known digests, handshake, mid-block reset, chaining.
module tb_md5_update;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic         en = 1'b0;
    logic [511:0] string_data = '0;
    logic [8:0]   input_len = '0;
    logic         complete;
    logic [31:0]  A, B, C, D;
    logic [127:0] dig;

`ifdef MD5_UNROLL2_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif
    localparam logic [127:0] IV_W    = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [127:0] EMPTY_W = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] ABC_W   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

    int           total = 0;
    int           bad = 0;
    logic [127:0] exp_q [$];
    int           s_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    logic [511:0] abc_blk, empty_blk;

    always #5 clk = ~clk;
    assign dig = {A, B, C, D};

    md5_update dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .en          (en),
        .string_data (string_data),
        .input_len   (input_len),
        .complete    (complete),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D)
    );

    // Reference compression straight from the RFC description; K derived from sin().
    function automatic logic [127:0] md5_model(input logic [127:0] st, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, k, t;
        int g, s;
        real r;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int n = 0; n < 64; n++) begin
            if (n < 16)      begin f = (b & c) | (~b & d); g = n; end
            else if (n < 32) begin f = (d & b) | (~d & c); g = (5 * n + 1) % 16; end
            else if (n < 48) begin f = b ^ c ^ d;          g = (3 * n + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * n) % 16; end
            r = $sin(real'(n + 1));
            if (r < 0.0) r = -r;
            k = 32'(longint'($floor(r * 4294967296.0)));
            t = a + f + k + blk[32*g +: 32];
            s = s_tab[(n / 16) * 4 + (n % 4)];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    task automatic pulse_init;
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
    endtask

    task automatic start_block(input logic [511:0] blk, input logic [8:0] len, input logic with_init);
        @(negedge clk);
        string_data = blk;
        input_len   = len;
        init        = with_init;
        en          = 1'b1;
    endtask

    // mode 0: en pulse, 1: en held, 2: en pulse plus a re-toggle mid-ROUND
    task automatic wait_done(input int mode, output int lat, output bit to);
        to = 1'b1; lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                init = 1'b0;
                string_data = {16{$urandom}};
                if (mode != 1) en = 1'b0;
            end
            if (mode == 2 && n == 10) en = 1'b1;
            if (mode == 2 && n == 13) en = 1'b0;
            if (complete) begin lat = n - 1; to = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (complete !== 1'b0) begin bad++; $display("FAIL reset_complete got=%b want=0", complete); end
        total++;
        if (dig !== IV_W) begin bad++; $display("FAIL reset_digest got=%h want=%h", dig, IV_W); end
        reset = 1'b0;
    endtask

    task automatic test_empty;
        int lat; bit to; logic [127:0] want;
        pulse_init();
        start_block(empty_blk, 9'd0, 1'b0);
        exp_q.push_back(EMPTY_W);
        wait_done(0, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL empty_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL empty_digest got=%h want=%h", dig, want); end
    endtask

    task automatic test_handshake;
        int lat; bit to; logic [127:0] want;
        pulse_init();
        start_block(abc_blk, 9'd3, 1'b0);
        exp_q.push_back(ABC_W);
        wait_done(1, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL hold_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL abc_digest got=%h want=%h", dig, want); end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (complete !== 1'b1 || dig !== want) begin
                bad++; $display("FAIL hold_complete got=%b/%h want=1/%h", complete, dig, want);
            end
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (complete !== 1'b0) begin bad++; $display("FAIL release_complete got=%b want=0", complete); end

        pulse_init();
        start_block(abc_blk, 9'd3, 1'b0);
        exp_q.push_back(ABC_W);
        wait_done(2, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL toggle_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL toggle_digest got=%h want=%h", dig, want); end
    endtask

    task automatic test_reset_mid;
        int lat; bit to; logic [127:0] want;
        start_block(empty_blk, 9'd0, 1'b0);
        @(negedge clk); en = 1'b0;
        repeat (29) @(negedge clk);
        total++;
        if (dig !== ABC_W) begin bad++; $display("FAIL round_digest_stable got=%h want=%h", dig, ABC_W); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (complete !== 1'b0) begin bad++; $display("FAIL midreset_complete got=%b want=0", complete); end
        total++;
        if (dig !== IV_W) begin bad++; $display("FAIL midreset_digest got=%h want=%h", dig, IV_W); end
        start_block(abc_blk, 9'd3, 1'b0);
        exp_q.push_back(ABC_W);
        wait_done(0, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL postreset_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL postreset_digest got=%h want=%h", dig, want); end
    endtask

    task automatic test_back_to_back;
        int lat; bit to; logic [127:0] want;
        // no init: second block chains from the "abc" digest; odd input_len is ignored
        start_block(abc_blk, 9'h1ff, 1'b0);
        exp_q.push_back(md5_model(ABC_W, abc_blk));
        wait_done(0, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL chain_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL chain_digest got=%h want=%h", dig, want); end
        // init together with en: block must start from the IV
        start_block(abc_blk, 9'd3, 1'b1);
        exp_q.push_back(ABC_W);
        wait_done(0, lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL reinit_latency got=%0d want=%0d timeout=%0d", lat, LAT, to); end
        want = exp_q.pop_front();
        total++;
        if (dig !== want) begin bad++; $display("FAIL reinit_digest got=%h want=%h", dig, want); end
    endtask

    initial begin
        empty_blk = '0;
        empty_blk[7:0] = 8'h80;
        abc_blk = '0;
        abc_blk[31:0] = 32'h80636261;
        abc_blk[455:448] = 8'h18;
        test_reset();
        test_empty();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/md5_update.md
Name: md5_update

Overview:
- Single-block MD5 compression engine.
- Takes one padded 512-bit message block and runs the 64 MD5 steps on it, one step per clock.
- Adds the result into internal chaining registers A..D, which are exposed as the running digest.
- Sits behind the keyboard/string assembler, which does message collection and padding and pulses `en` once per block.

Parameters:
- ROUNDS_PER_CYCLE, 1, number of MD5 steps evaluated per clock. 1 in base build; forced to 2 by the optional feature.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  reload chaining registers with the IV. Honoured only in IDLE/DONE.
- en  input  1  start request; level-sampled in IDLE.
- string  input  512  padded block. Word M[j] = string[32j+31:32j], little-endian bytes: message byte 0 = string[7:0].
- input_len  input  9  bytes of message data in this block (0..64). Latched with the block; has no effect on the computation.
- complete  output  1  high from block finish until `en` is low.
- A, B, C, D  output  32 each  chaining/digest words (little-endian MD5 word convention).

Behaviour:
- Reset:
  - State goes to IDLE; complete=0.
  - A=0x67452301, B=0xEFCDAB89, C=0x98BADCFE, D=0x10325476.
  - Step counter = 0; working regs cleared.
  - Reset wins over every other input, including mid-block.
- IDLE:
  - init=1 reloads the IV. If en=1 in the same cycle, init applies first, so the block uses the IV.
  - en=1 latches string and input_len, copies A..D into working regs a,b,c,d, sets i=0, goes to ROUND.
- ROUND, step i:
  - F,g by quarter: i<16: F=(b&c)|(~b&d), g=i. i<32: F=(d&b)|(~d&c), g=(5i+1) mod 16. i<48: F=b^c^d, g=(3i+5) mod 16. else: F=c^(b|~d), g=(7i) mod 16.
  - tmp = a+F+K[i]+M[g], all mod 2^32.
  - Update: a<=d, d<=c, c<=b, b<=b+rotl(tmp,S[i]).
  - K[i]=floor(abs(sin(i+1))*2^32). S per RFC 1321 (7,12,17,22 / 5,9,14,20 / 4,11,16,23 / 6,10,15,21).
  - After i=63, go to ADD.
- ADD: A+=a, B+=b, C+=c, D+=d (mod 2^32); complete<=1; go to DONE.
- DONE:
  - complete held 1. A..D stable.
  - en=0 clears complete and returns to IDLE. init is honoured here too.
- Latency: en sampled at edge k → complete=1 after edge k+65 (64 ROUND + 1 ADD). Outputs valid when complete=1.
- en high during ROUND/ADD is ignored; string changes after the latch edge have no effect.
- A..D change only in ADD, on reset, or on init. Successive blocks chain unless init is pulsed between messages.
- input_len >64 is accepted without error; it is not used.

Optional Feature:
- Macro MD5_UNROLL2_EN.
- Defined: two steps per clock, computed combinationally in series. ROUND lasts 32 cycles; complete after edge k+33.
- Undefined: one step per clock, latency 65 as above.
- Results are identical either way.

Decomposition:
- Package md5_pkg holds:
  - K[0:63] constant table and S[0:63] shift table
  - IV constants
  - state enum {IDLE, ROUND, ADD, DONE}
  - function for g index
- Natural sub-module md5_step: combinational single MD5 step.
  - Inputs: a,b,c,d, M[g], i. Outputs: next a,b,c,d.
  - Instantiated once, or twice chained under MD5_UNROLL2_EN.

Test Plan:
- Empty message: reset, init; string byte0=0x80, rest 0; en=1 → complete after 65 edges; A=0xd98c1dd4, B=0x04b2008f, C=0x980980e9, D=0x7e42f8ec.
- "abc": reset, init; bytes 0..3 = 61 62 63 80, string[455:448]=0x18, rest 0; en → A=0x98500190, B=0xb04fd23c, C=0x7d3f96d6, D=0x727fe128.
- Handshake: hold en high through completion → complete stays 1 until en=0, then 0 next cycle. Toggling en mid-ROUND causes no restart; latency unchanged.
- Reset mid-operation at step 30 → next cycle complete=0, A..D=IV. A fresh "abc" block then gives the "abc" digest.
- Chaining: "abc" block twice, no init between → second digest equals a golden-model compression from the first digest. Pulse init, then "abc" → original "abc" digest.
- With MD5_UNROLL2_EN: repeat the first two tests → identical digests; complete after 33 edges.
